// File: rtl/clock_sequencer.sv
// Clock-enable scheduler and reset sequencer for the Lynx core: holds the system
// in reset until the DCM locks, then issues pixel/CRTC/CPU enables and video-slot arbitration.
module clock_sequencer #(
  parameter int RESET_HOLD = 16,
  parameter int CRTC_DIV   = 16,
  parameter int MAX_DEFER  = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic locked,
  input  logic turbo,
  input  logic pause,
  input  logic vreq,
  output logic rst_sys_n,
  output logic ce_pix,
  output logic ce_crtc,
  output logic ce_cpu_p,
  output logic ce_cpu_n,
  output logic vgrant,
  output logic stall,
  output logic speed
);

  typedef enum logic {HOLD, RUN} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(RESET_HOLD - 1);
  localparam logic [3:0] CRTC_MASK = 4'(CRTC_DIV - 1);
  localparam logic [7:0] DEFER_MAX = 8'(MAX_DEFER);

  state_t     state;
  logic       lock_meta;
  logic       lock_sync;
  logic [7:0] hcnt;
  logic [3:0] cnt;
  logic [2:0] ph;
  logic [7:0] defer;
  logic [2:0] ph_last;
  logic [2:0] ph_half;
  logic       crtc_hit;

  // Period P is 4 at 6 MHz and 6 at 4 MHz; speed only changes at ph == P-1.
  assign ph_last  = speed ? 3'd3 : 3'd5;
  assign ph_half  = speed ? 3'd2 : 3'd3;
  assign crtc_hit = (cnt & CRTC_MASK) == CRTC_MASK;

  // locked comes straight from the DCM in no particular timing relation to clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= locked;
      lock_sync <= lock_meta;
    end
  end

  // NOTE: every register here uses non-blocking assignment so all outputs are
  // computed from the same pre-edge state; the leading defaults are overridden below.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= HOLD;
      hcnt      <= '0;
      cnt       <= '0;
      ph        <= '0;
      defer     <= '0;
      rst_sys_n <= 1'b0;
      ce_pix    <= 1'b0;
      ce_crtc   <= 1'b0;
      ce_cpu_p  <= 1'b0;
      ce_cpu_n  <= 1'b0;
      vgrant    <= 1'b0;
      stall     <= 1'b0;
      speed     <= 1'b0;
    end else begin
      ce_pix   <= 1'b0;
      ce_crtc  <= 1'b0;
      ce_cpu_p <= 1'b0;
      ce_cpu_n <= 1'b0;
      vgrant   <= 1'b0;
      stall    <= 1'b0;
      case (state)
        HOLD: begin
          cnt   <= '0;
          ph    <= '0;
          defer <= '0;
          speed <= 1'b0;
          if (!lock_sync) begin
            hcnt <= '0;
          end else if (hcnt == HOLD_LAST) begin
            hcnt      <= '0;
            state     <= RUN;
            rst_sys_n <= 1'b1;
          end else begin
            hcnt <= hcnt + 8'd1;
          end
        end
        RUN: begin
          if (!lock_sync) begin
            state     <= HOLD;
            rst_sys_n <= 1'b0;
            hcnt      <= '0;
            cnt       <= '0;
            ph        <= '0;
            defer     <= '0;
            speed     <= 1'b0;
          end else begin
            cnt     <= cnt + 4'd1;
            ce_pix  <= cnt[0];
            ce_crtc <= crtc_hit;
            if (ph == 3'd0) begin
              // CPU edge due: pause beats everything, then video may defer it a bounded number of times.
              if (pause) begin
                vgrant <= vreq;
                defer  <= '0;
              end else if (vreq && (defer < DEFER_MAX)) begin
                vgrant <= 1'b1;
                stall  <= 1'b1;
                defer  <= defer + 8'd1;
              end else begin
                ce_cpu_p <= 1'b1;
                ph       <= 3'd1;
                defer    <= '0;
              end
            end else begin
              vgrant   <= vreq;
              ce_cpu_n <= (ph == ph_half);
              if (ph == ph_last) begin
                ph    <= 3'd0;
                speed <= turbo;
              end else begin
                ph <= ph + 3'd1;
              end
            end
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule
